// File: rtl/bsram_arb_pkg.sv
// bsram_arb_pkg: shared constants and types for the BSRAM arbiter.
//   ADDR_W/DATA_W/DEPTH describe the 8 KB simple-dual-port BSRAM.
//   CLEAR_BYTE is the fill value written by the optional init sweep.
//   owner_e tags each issued read with its requester.
//   state_e is the arbiter's INIT/RUN state.
package bsram_arb_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8192;
  localparam logic [7:0] CLEAR_BYTE = 8'h20;

  typedef enum logic [1:0] {OWN_NONE, OWN_LCD, OWN_CPU} owner_e;
  typedef enum logic {ST_INIT, ST_RUN} state_e;

endpackage

// File: rtl/bsram_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: fixed-depth shift register of read-owner tags. It tracks
// which requester owns the data emerging from the BSRAM output register.
//   clk      in   clock
//   rst      in   asynchronous active-high clear (all stages -> OWN_NONE)
//   tag_in   in   tag loaded into stage 0 every cycle (OWN_NONE when idle)
//   tag_out  out  tag leaving the last stage
module rd_tag_pipe
  import bsram_arb_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  owner_e tag_in,
  output owner_e tag_out
);

  owner_e stage [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) stage[i] <= OWN_NONE;
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[STAGES-1];

endmodule

// File: rtl/bsram_arbiter.sv
// bsram_arbiter: shares the BSRAM read port between LCD fetch and CPU,
// passes CPU writes straight to the write port, and drives every BSRAM pin.
// Optional macro: BSRAM_CLEAR_EN -- INIT fills the whole RAM with CLEAR_BYTE
// (one address per cycle) before accepting requests.
//   clk, rst                     clock, async active-high reset
//   lcd_req/lcd_addr/lcd_gnt     LCD read request, address, same-cycle grant
//   lcd_rvalid/lcd_rdata         LCD read return (one-cycle pulse)
//   cpu_req/cpu_we/cpu_addr/
//   cpu_wdata/cpu_gnt            CPU request (held until cpu_gnt)
//   cpu_rvalid/cpu_rdata         CPU read return (one-cycle pulse)
//   init_done                    arbiter is in RUN
//   bram_*                       BSRAM enables, resets, addresses, data
module bsram_arbiter
  import bsram_arb_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lcd_req,
  input  logic [ADDR_W-1:0] lcd_addr,
  output logic              lcd_gnt,
  output logic              lcd_rvalid,
  output logic [DATA_W-1:0] lcd_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              init_done,
  output logic              bram_cea,
  output logic              bram_ceb,
  output logic              bram_oce,
  output logic              bram_reseta,
  output logic              bram_resetb,
  output logic [ADDR_W-1:0] bram_ada,
  output logic [ADDR_W-1:0] bram_adb,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e     state, state_next;
  logic [3:0] starve;
  logic       cpu_rd;
  owner_e     push_tag, pop_tag;

`ifdef BSRAM_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  clr_addr <= '0;
    else if (state == ST_INIT) clr_addr <= clr_addr + 1'b1;
  end
`endif

  assign cpu_rd      = cpu_req & ~cpu_we;
  assign bram_oce    = 1'b1;
  assign bram_reseta = rst;
  assign bram_resetb = rst;
  assign init_done   = (state == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_INIT;
    else     state <= state_next;
  end

  // Counts consecutive lost arbitration rounds of a pending CPU read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           starve <= '0;
    else if (state != ST_RUN || !cpu_rd || cpu_gnt)    starve <= '0;
    else if (starve != LIMIT)                          starve <= starve + 4'd1;
  end

  // Grants and BSRAM controls are combinational so a read is issued in its
  // grant cycle; the tag pipe then lines up with the BSRAM output register.
  always_comb begin
    state_next = state;
    lcd_gnt    = 1'b0;
    cpu_gnt    = 1'b0;
    bram_cea   = 1'b0;
    bram_ceb   = 1'b0;
    bram_ada   = '0;
    bram_adb   = '0;
    bram_din   = '0;
    push_tag   = OWN_NONE;
    unique case (state)
      ST_INIT: begin
`ifdef BSRAM_CLEAR_EN
        bram_cea = 1'b1;
        bram_ada = clr_addr;
        bram_din = CLEAR_BYTE;
        if (clr_addr == ADDR_W'(DEPTH - 1)) state_next = ST_RUN;
`else
        state_next = ST_RUN;
`endif
      end
      ST_RUN: begin
        if (cpu_req && cpu_we) begin
          cpu_gnt  = 1'b1;
          bram_cea = 1'b1;
          bram_ada = cpu_addr;
          bram_din = cpu_wdata;
        end
        if (cpu_rd && (!lcd_req || starve == LIMIT)) begin
          cpu_gnt  = 1'b1;
          bram_ceb = 1'b1;
          bram_adb = cpu_addr;
          push_tag = OWN_CPU;
        end else if (lcd_req) begin
          lcd_gnt  = 1'b1;
          bram_ceb = 1'b1;
          bram_adb = lcd_addr;
          push_tag = OWN_LCD;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  rd_tag_pipe #(.STAGES(READ_LATENCY)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (push_tag),
    .tag_out (pop_tag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcd_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      lcd_rdata  <= '0;
      cpu_rdata  <= '0;
    end else begin
      lcd_rvalid <= (pop_tag == OWN_LCD);
      cpu_rvalid <= (pop_tag == OWN_CPU);
      if (pop_tag == OWN_LCD) lcd_rdata <= bram_dout;
      if (pop_tag == OWN_CPU) cpu_rdata <= bram_dout;
    end
  end

endmodule

// File: tb/tb_bsram_arbiter.sv
// tb_bsram_arbiter: randomized and directed bench for bsram_arbiter with a
// behavioural BSRAM and a transaction-level reference model.
// Honours BSRAM_CLEAR_EN when defined.
module tb_bsram_arbiter;

  localparam int RL = 2;
  localparam int SL = 4;
`ifdef BSRAM_CLEAR_EN
  localparam int INIT_CYCLES = 8192;
`else
  localparam int INIT_CYCLES = 1;
`endif

  logic        clk, rst;
  logic        lcd_req, lcd_gnt, lcd_rvalid;
  logic [12:0] lcd_addr;
  logic [7:0]  lcd_rdata;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        init_done;
  logic        bram_cea, bram_ceb, bram_oce, bram_reseta, bram_resetb;
  logic [12:0] bram_ada, bram_adb;
  logic [7:0]  bram_din, bram_dout;

  bsram_arbiter #(.READ_LATENCY(RL), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .lcd_req(lcd_req), .lcd_addr(lcd_addr), .lcd_gnt(lcd_gnt),
    .lcd_rvalid(lcd_rvalid), .lcd_rdata(lcd_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .init_done(init_done),
    .bram_cea(bram_cea), .bram_ceb(bram_ceb), .bram_oce(bram_oce),
    .bram_reseta(bram_reseta), .bram_resetb(bram_resetb),
    .bram_ada(bram_ada), .bram_adb(bram_adb), .bram_din(bram_din),
    .bram_dout(bram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural BSRAM: read-before-write, RL cycles from ceb to dout.
  logic [7:0] bmem [8192];
  logic [7:0] rd_pipe [RL];
  bit loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 8192; i++) bmem[i] <= 8'(i * 7 + 3);
      for (int i = 0; i < RL; i++) rd_pipe[i] <= 8'h00;
      loaded <= 1'b1;
    end else begin
      if (bram_ceb) rd_pipe[0] <= bmem[bram_adb];
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (bram_cea) bmem[bram_ada] <= bram_din;
    end
  end
  assign bram_dout = rd_pipe[RL-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int denied = 0;
  logic [7:0] ref_mem [8192];

  typedef struct { int owner; logic [7:0] data; int due; } rd_t;
  typedef struct { logic lg, cg, lrv, crv; logic [7:0] lrd, crd; } exp_t;
  rd_t exp_q[$];

  // Transaction-level model: decides this cycle's grants from the priority
  // rules and schedules each read's return RL+1 cycles later.
  task automatic model_eval(output exp_t e);
    bit   cpu_read, cpu_wins;
    rd_t  r;
    e = '{default: '0};
    if (cyc >= INIT_CYCLES) begin
      cpu_read = cpu_req && !cpu_we;
      cpu_wins = cpu_read && (!lcd_req || denied >= SL);
      r.due = cyc + RL + 1;
      if (cpu_wins) begin
        e.cg = 1'b1; r.owner = 2; r.data = ref_mem[cpu_addr]; exp_q.push_back(r);
      end else if (lcd_req) begin
        e.lg = 1'b1; r.owner = 1; r.data = ref_mem[lcd_addr]; exp_q.push_back(r);
      end
      denied = (cpu_read && !cpu_wins) ? ((denied < SL) ? denied + 1 : SL) : 0;
      if (cpu_req && cpu_we) begin
        e.cg = 1'b1;
        ref_mem[cpu_addr] = cpu_wdata;
      end
    end else begin
      denied = 0;
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      if (exp_q[0].owner == 1) begin e.lrv = 1'b1; e.lrd = exp_q[0].data; end
      else                     begin e.crv = 1'b1; e.crd = exp_q[0].data; end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle();
    lcd_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    denied = 0;
    exp_q.delete();
`ifdef BSRAM_CLEAR_EN
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h20;
`endif
  endtask

  task automatic test_init();
    exp_t e;
    while (cyc < INIT_CYCLES) begin
      lcd_req = 1'($urandom); lcd_addr = 13'($urandom);
      cpu_req = 1'($urandom); cpu_we = 1'($urandom);
      cpu_addr = 13'($urandom); cpu_wdata = 8'($urandom);
      #2;
      model_eval(e);
      checks++;
      if ({lcd_gnt, cpu_gnt, init_done, lcd_rvalid, cpu_rvalid} !== 5'b0) begin
        errors++;
        $display("FAIL init_quiet cyc=%0d: got gnt/done/rv=%b want 00000", cyc,
                 {lcd_gnt, cpu_gnt, init_done, lcd_rvalid, cpu_rvalid});
      end
`ifdef BSRAM_CLEAR_EN
      checks++;
      if ({bram_cea, bram_ada, bram_din} !== {1'b1, 13'(cyc), 8'h20}) begin
        errors++;
        $display("FAIL init_sweep cyc=%0d: got cea=%b ada=%h din=%h want 1 %h 20", cyc,
                 bram_cea, bram_ada, bram_din, 13'(cyc));
      end
`endif
      next_cycle();
    end
    idle();
    #2;
    model_eval(e);
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done cyc=%0d: got %b want 1", cyc, init_done);
    end
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lcd_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    lcd_addr = 13'h0123; cpu_addr = 13'h0456; cpu_wdata = 8'h77;
    repeat (3) @(posedge clk);
    #4;
    checks++;
    if ({lcd_gnt, cpu_gnt, lcd_rvalid, cpu_rvalid, bram_cea, bram_ceb, init_done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {lcd_gnt, cpu_gnt, lcd_rvalid, cpu_rvalid, bram_cea, bram_ceb, init_done});
    end
    checks++;
    if ({lcd_rdata, cpu_rdata, bram_din, bram_ada, bram_adb} !== 50'b0) begin
      errors++;
      $display("FAIL reset_data: got rd=%h/%h din=%h ada=%h adb=%h want 0",
               lcd_rdata, cpu_rdata, bram_din, bram_ada, bram_adb);
    end
    checks++;
    if ({bram_oce, bram_reseta, bram_resetb} !== 3'b111) begin
      errors++;
      $display("FAIL reset_pins: got %b want 111", {bram_oce, bram_reseta, bram_resetb});
    end
    idle();
    release_reset();
    test_init();
  endtask

  task automatic test_write_read();
    exp_t e;
    idle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0010; cpu_wdata = 8'hA5;
    #2;
    model_eval(e);
    checks++;
    if ({cpu_gnt, bram_cea, bram_ada, bram_din} !== {1'b1, 1'b1, 13'h0010, 8'hA5}) begin
      errors++;
      $display("FAIL wr_grant: got gnt=%b cea=%b ada=%h din=%h want 1 1 0010 a5",
               cpu_gnt, bram_cea, bram_ada, bram_din);
    end
    next_cycle();
    cpu_we = 1'b0;
    #2;
    model_eval(e);
    checks++;
    if ({cpu_gnt, bram_ceb, bram_adb, bram_cea} !== {1'b1, 1'b1, 13'h0010, 1'b0}) begin
      errors++;
      $display("FAIL rd_grant: got gnt=%b ceb=%b adb=%h cea=%b want 1 1 0010 0",
               cpu_gnt, bram_ceb, bram_adb, bram_cea);
    end
    next_cycle();
    idle();
    for (int k = 1; k <= 3; k++) begin
      #2;
      model_eval(e);
      checks++;
      if (cpu_rvalid !== (k == 3)) begin
        errors++;
        $display("FAIL rd_latency k=%0d: got rvalid=%b want %b", k, cpu_rvalid, (k == 3));
      end
      if (k == 3) begin
        checks++;
        if (cpu_rdata !== 8'hA5) begin
          errors++;
          $display("FAIL rd_data: got %h want a5", cpu_rdata);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_starve();
    exp_t e;
    idle();
    lcd_req = 1'b1; lcd_addr = 13'h0200;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0001;
    for (int i = 0; i <= SL; i++) begin
      #2;
      model_eval(e);
      checks++;
      if ({lcd_gnt, cpu_gnt} !== {i != SL, i == SL}) begin
        errors++;
        $display("FAIL starve_round%0d: got lcd/cpu gnt=%b%b want %b%b", i,
                 lcd_gnt, cpu_gnt, i != SL, i == SL);
      end
      next_cycle();
    end
    cpu_req = 1'b0;
    #2;
    model_eval(e);
    checks++;
    if (lcd_gnt !== 1'b1) begin
      errors++;
      $display("FAIL starve_lcd_after: got %b want 1", lcd_gnt);
    end
    next_cycle();
    idle();
    for (int k = 0; k < RL + 2; k++) begin
      #2;
      model_eval(e);
      checks++;
      if ({lcd_rvalid, cpu_rvalid} !== {e.lrv, e.crv} ||
          (e.crv && cpu_rdata !== e.crd) || (e.lrv && lcd_rdata !== e.lrd)) begin
        errors++;
        $display("FAIL starve_return: got rv=%b%b data=%h/%h want %b%b %h/%h",
                 lcd_rvalid, cpu_rvalid, lcd_rdata, cpu_rdata, e.lrv, e.crv, e.lrd, e.crd);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [7:0] d;
    idle();
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'(i); cpu_wdata = 8'(8'h11 * (i + 1));
      #2;
      model_eval(e);
      checks++;
      if (cpu_gnt !== 1'b1) begin
        errors++;
        $display("FAIL preload%0d: got gnt=%b want 1", i, cpu_gnt);
      end
      next_cycle();
    end
    idle();
    for (int i = 0; i < 7; i++) begin
      idle();
      if (i < 4) begin
        if (i % 2 == 0) begin lcd_req = 1'b1; lcd_addr = 13'(i); end
        else begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'(i); end
      end
      #2;
      model_eval(e);
      if (i < 4) begin
        checks++;
        if ({lcd_gnt, cpu_gnt} !== {i % 2 == 0, i % 2 == 1}) begin
          errors++;
          $display("FAIL b2b_gnt%0d: got %b%b", i, lcd_gnt, cpu_gnt);
        end
      end
      if (i >= 3) begin
        d = 8'(8'h11 * (i - 2));
        checks++;
        if ({lcd_rvalid, cpu_rvalid} !== {(i - 3) % 2 == 0, (i - 3) % 2 == 1} ||
            ((i - 3) % 2 == 0 && lcd_rdata !== d) || ((i - 3) % 2 == 1 && cpu_rdata !== d)) begin
          errors++;
          $display("FAIL b2b_return%0d: got rv=%b%b data=%h/%h want data %h", i - 3,
                   lcd_rvalid, cpu_rvalid, lcd_rdata, cpu_rdata, d);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_concurrent_write();
    exp_t e;
    logic [7:0] w;
    w = 8'($urandom);
    idle();
    lcd_req = 1'b1; lcd_addr = 13'h0100;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1FFF; cpu_wdata = w;
    #2;
    model_eval(e);
    checks++;
    if ({lcd_gnt, cpu_gnt, bram_cea, bram_ceb, bram_ada, bram_adb} !==
        {4'hF, 13'h1FFF, 13'h0100}) begin
      errors++;
      $display("FAIL concurrent: got gnt=%b%b ce=%b%b ada=%h adb=%h want 1111 1fff 0100",
               lcd_gnt, cpu_gnt, bram_cea, bram_ceb, bram_ada, bram_adb);
    end
    next_cycle();
    idle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1FFF;
    #2;
    model_eval(e);
    next_cycle();
    idle();
    for (int k = 0; k < RL + 2; k++) begin
      #2;
      model_eval(e);
      checks++;
      if ({lcd_rvalid, cpu_rvalid} !== {e.lrv, e.crv} ||
          (e.crv && cpu_rdata !== w) || (e.lrv && lcd_rdata !== e.lrd)) begin
        errors++;
        $display("FAIL concurrent_return: got rv=%b%b data=%h/%h want %b%b %h/%h",
                 lcd_rvalid, cpu_rvalid, lcd_rdata, cpu_rdata, e.lrv, e.crv, e.lrd, w);
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    exp_t e;
    bit pend = 1'b0;
    idle();
    for (int n = 0; n < 600; n++) begin
      if (n < 600 - (RL + 2)) begin
        lcd_req = ($urandom_range(0, 9) < 7);
        lcd_addr = 13'($urandom_range(0, 15));
        if (!pend && $urandom_range(0, 2) != 0) begin
          pend = 1'b1;
          cpu_we = 1'($urandom);
          cpu_addr = 13'($urandom_range(0, 15));
          cpu_wdata = 8'($urandom);
        end
        cpu_req = pend;
      end else begin
        idle();
      end
      #2;
      model_eval(e);
      checks++;
      if ({lcd_gnt, cpu_gnt} !== {e.lg, e.cg}) begin
        errors++;
        $display("FAIL rand_gnt n=%0d: got lcd/cpu=%b%b want %b%b", n, lcd_gnt, cpu_gnt, e.lg, e.cg);
      end
      checks++;
      if ({lcd_rvalid, cpu_rvalid} !== {e.lrv, e.crv}) begin
        errors++;
        $display("FAIL rand_rvalid n=%0d: got %b%b want %b%b", n, lcd_rvalid, cpu_rvalid, e.lrv, e.crv);
      end
      if (e.lrv) begin
        checks++;
        if (lcd_rdata !== e.lrd) begin
          errors++;
          $display("FAIL rand_lcd_data n=%0d: got %h want %h", n, lcd_rdata, e.lrd);
        end
      end
      if (e.crv) begin
        checks++;
        if (cpu_rdata !== e.crd) begin
          errors++;
          $display("FAIL rand_cpu_data n=%0d: got %h want %h", n, cpu_rdata, e.crd);
        end
      end
      if (e.cg) pend = 1'b0;
      next_cycle();
    end
  endtask

  task automatic test_reset_inflight();
    exp_t e;
    idle();
    lcd_req = 1'b1; lcd_addr = 13'h0005;
    #2; model_eval(e); next_cycle();
    idle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0006;
    #2; model_eval(e); next_cycle();
    idle();
    rst = 1'b1;
    exp_q.delete();
    #1;
    checks++;
    if ({lcd_gnt, cpu_gnt, lcd_rvalid, cpu_rvalid, bram_cea, bram_ceb, init_done,
         lcd_rdata, cpu_rdata, bram_ada, bram_adb, bram_din} !== 57'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got gnt=%b%b rv=%b%b ce=%b%b done=%b rd=%h/%h",
               lcd_gnt, cpu_gnt, lcd_rvalid, cpu_rvalid, bram_cea, bram_ceb, init_done,
               lcd_rdata, cpu_rdata);
    end
    for (int k = 0; k < RL + 3; k++) begin
      @(posedge clk);
      #4;
      checks++;
      if ({lcd_rvalid, cpu_rvalid, init_done} !== 3'b000) begin
        errors++;
        $display("FAIL midreset_quiet%0d: got rv=%b%b done=%b want 000", k,
                 lcd_rvalid, cpu_rvalid, init_done);
      end
    end
    release_reset();
    test_init();
  endtask

  task automatic test_after_reset_read();
    exp_t e;
    logic [7:0] want;
`ifdef BSRAM_CLEAR_EN
    want = 8'h20;
`else
    want = ref_mem[13'h1FFF];
`endif
    idle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1FFF;
    #2;
    model_eval(e);
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_gnt: got %b want 1", cpu_gnt);
    end
    next_cycle();
    idle();
    for (int k = 1; k <= RL + 1; k++) begin
      #2;
      model_eval(e);
      if (k == RL + 1) begin
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== want) begin
          errors++;
          $display("FAIL post_reset_data: got rv=%b data=%h want 1 %h", cpu_rvalid, cpu_rdata, want);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    lcd_addr = '0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'(i * 7 + 3);
    test_reset();
    test_write_read();
    test_starve();
    test_back_to_back();
    test_concurrent_write();
    test_random();
    test_reset_inflight();
    test_after_reset_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsram_arbiter.md
Name: bsram_arbiter

Overview:
Shares the 8 KB simple-dual-port BSRAM (13-bit address, 8-bit data; write on port A, read on port B) between the LCD character fetch and the CPU. The LCD has priority on the read port. A starvation limiter prevents CPU read lockout. CPU writes go to port A independently of reads. Sits in top between the requesters and the Gowin_SDPB instance and drives all of its control pins.

Parameters:
READ_LATENCY, 2, cycles from ceb-issue to valid bram_dout (output register mode, oce held 1); legal 1..3
STARVE_LIMIT, 4, consecutive cycles a CPU read may lose to the LCD before it is forced through; legal 1..15

Ports:
clk  in  1  BSRAM clock (XTAL_IN domain)
rst  in  1  asynchronous active-high reset
lcd_req  in  1  LCD read request
lcd_addr  in  13  LCD read address
lcd_gnt  out  1  LCD read issued this cycle (combinational)
lcd_rvalid  out  1  lcd_rdata valid, one-cycle pulse
lcd_rdata  out  8  LCD read data
cpu_req  in  1  CPU request; hold cpu_addr/cpu_we/cpu_wdata stable until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  13  CPU address
cpu_wdata  in  8  CPU write data
cpu_gnt  out  1  CPU request accepted this cycle (combinational)
cpu_rvalid  out  1  cpu_rdata valid, one-cycle pulse
cpu_rdata  out  8  CPU read data
init_done  out  1  arbiter accepting requests
bram_cea, bram_ceb, bram_oce, bram_reseta, bram_resetb  out  1 each  BSRAM enables/resets
bram_ada, bram_adb  out  13 each  BSRAM write/read address
bram_din  out  8  BSRAM write data
bram_dout  in  8  BSRAM read data

Behaviour:
- Reset values: all gnt/rvalid 0, rdata 0, cea/ceb 0, ada/adb/din 0, init_done 0, starve counter 0, tag pipe all NONE. bram_oce is constant 1. bram_reseta = bram_resetb = rst.
- FSM states: INIT, RUN. Reset enters INIT. Without the optional feature, INIT lasts exactly 1 cycle, then RUN with init_done = 1. No grants in INIT.
- CPU write in RUN: always granted the same cycle. cea = 1, ada = cpu_addr, din = cpu_wdata. Never blocks the read port.
- Read port, per cycle:
  - Only LCD requesting: LCD granted.
  - Only CPU read requesting: CPU granted.
  - Both requesting: LCD wins unless the starve counter equals STARVE_LIMIT, in which case CPU wins.
- Granted read: ceb = 1, adb = granted address, owner tag pushed into a READ_LATENCY-deep pipe. When the tag exits the pipe, bram_dout is registered into the owner's rdata and rvalid pulses. Total latency is READ_LATENCY+1 cycles from gnt to rvalid, fixed and in order.
- Starve counter:
  - Increments each cycle a pending CPU read is denied.
  - Saturates at STARVE_LIMIT.
  - Clears when the CPU read is granted or cpu_req drops.
- Read-after-write hazard: a CPU read whose address equals the write address of the previous cycle is allowed. A same-cycle read/write pair cannot occur (one CPU request per cycle). An LCD read that matches a same-cycle CPU write address returns old data. This is documented and not forwarded.
- Ungranted requests have no side effects. The CPU can have up to READ_LATENCY+1 reads in flight.
- Reset mid-operation: in-flight reads are discarded with no rvalid, the FSM returns to INIT, and the counter clears.

Optional Feature:
BSRAM_CLEAR_EN
- Defined: INIT sweeps port A, writing 8'h20 (space) to addresses 0..8191, one per cycle (8192 cycles). init_done rises the cycle after address 8191 is written. All gnt stay 0 during the sweep.
- Undefined: no sweep; INIT lasts 1 cycle.

Decomposition:
- Package bsram_arb_pkg:
  - ADDR_W = 13, DATA_W = 8, DEPTH = 8192, CLEAR_BYTE = 8'h20
  - typedef enum logic [1:0] owner_e {OWN_NONE, OWN_LCD, OWN_CPU}
  - typedef enum logic state_e {ST_INIT, ST_RUN}
- Sub-module rd_tag_pipe: parameterised-depth shift register of owner_e with synchronous load and asynchronous clear.

Test Plan:
- After reset release, CPU writes 8'hA5 to 13'h0010, then reads 13'h0010 -> cpu_gnt same cycle; cpu_rvalid 3 cycles after the read gnt with cpu_rdata = 8'hA5.
- lcd_req held high continuously with CPU read pending to 13'h0001, STARVE_LIMIT = 4 -> LCD granted 4 cycles, CPU granted on the 5th, lcd_gnt = 0 that cycle, LCD granted again after.
- Back-to-back alternating LCD/CPU reads to 13'h0000..13'h0003 preloaded with 11,22,33,44 -> each rvalid routed to the correct owner, in issue order, with the matching data.
- CPU write to 13'h1FFF concurrent with LCD read of 13'h0100 -> both granted in the same cycle, cea = ceb = 1.
- Assert rst while 2 reads are in flight -> no rvalid afterwards, all outputs at reset values, init_done = 0.
- With BSRAM_CLEAR_EN: read 13'h1FFF after init_done -> 8'h20; cpu_gnt = 0 throughout the 8192-cycle sweep.
